mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multi-cycle processor's MemRead/MemWrite strobes.
//  Holds a single-port DEPTH x DATA_W array for both instructions and data.
//  Services one request at a time, with a programmable access latency.
//  Returns read data with a one-cycle valid pulse and signals write completion.
//  Has a preload port so benches and boot logic can fill memory.
// PARAMETERS
//  ADDR_W  8    address width
//  DATA_W  8    data width
//  DEPTH   256  words in array (must equal 2**ADDR_W)
//  RD_LAT  2    edges from read accept to rvalid; legal range 1..15
//  WR_LAT  1    edges from write accept to commit/wdone; legal range 1..15
// PORTS
//  clock    in   1       rising-edge clock
//  reset    in   1       asynchronous, active-high
//  MemRead  in   1       read request strobe, sampled each edge
//  MemWrite in   1       write request strobe, sampled each edge
//  addr     in   ADDR_W  request address
//  wdata    in   DATA_W  write data
//  ld_en    in   1       preload write enable
//  ld_addr  in   ADDR_W  preload address
//  ld_data  in   DATA_W  preload data
//  rdata    out  DATA_W  read data; holds last read value
//  rvalid   out  1       1-cycle pulse: rdata updated this cycle
//  wdone    out  1       1-cycle pulse: write committed this cycle
//  busy     out  1       access in progress; requests not accepted
//  err      out  1       1-cycle pulse: illegal or dropped request
// BEHAVIOUR
//  Reset:
//   - Outputs: rdata=0, rvalid=0, wdone=0, busy=0, err=0.
//   - State goes to IDLE and cnt=0.
//   - Array contents are NOT reset.
//  States: IDLE, RD_WAIT, WR_WAIT. The state is registered; busy = (state != IDLE).
//  IDLE, evaluated at each edge in this priority order:
//   1. ld_en: mem[ld_addr] <= ld_data; processor strobes in the same cycle are dropped with err=1.
//   2. MemRead & MemWrite: no access; err=1; stay in IDLE.
//   3. MemRead: latch addr; cnt <= RD_LAT; go to RD_WAIT.
//   4. MemWrite: latch addr and wdata; cnt <= WR_LAT; go to WR_WAIT.
//  RD_WAIT:
//   - Each edge: cnt <= cnt-1.
//   - At the edge where cnt==1: rdata <= mem[addr_q]; rvalid=1 for the next cycle; go to IDLE.
//   - Read accepted at edge k -> rvalid high between edge k+RD_LAT and edge k+RD_LAT+1.
//  WR_WAIT:
//   - Same countdown as RD_WAIT.
//   - At the edge where cnt==1: mem[addr_q] <= wdata_q; wdone=1 for one cycle; go to IDLE.
//   - The array is unchanged before that edge.
//  Busy handling:
//   - Any MemRead, MemWrite or ld_en seen while busy is dropped.
//   - A dropped request raises err=1 for one cycle; the in-flight access is unaffected.
//  Back-to-back:
//   - A new request is accepted in the cycle rvalid/wdone is high, because the state is IDLE then.
//   - Sustained throughput is one access per LAT+1 cycles.
//  Read-after-write to the same address returns the committed data.
//  Addresses are used modulo DEPTH; there is no out-of-range error.
//  Reset mid-operation:
//   - The access is aborted.
//   - A pending write is never committed.
//   - No rvalid/wdone pulse is produced.
//  rvalid, wdone and err are mutually exclusive, with one exception: err may coincide with rvalid/wdone
//   only if a request arrives at the completion edge while the state is still WAIT.
// TESTING
//  1. RD_LAT=2: preload mem[0x10]=0xA5; MemRead addr=0x10 at edge k
//     -> busy=1 for edges k..k+1; rvalid=1 and rdata=0xA5 after edge k+2.
//  2. WR_LAT=1: MemWrite addr=0x20 wdata=0x3C at edge k
//     -> wdone after edge k+1; a read of 0x20 issued in the wdone cycle returns 0x3C.
//  3. MemRead=MemWrite=1 in IDLE
//     -> err pulse; busy stays 0; no rvalid/wdone; memory unchanged.
//  4. MemRead of 0x10 while RD_WAIT for 0x11 is in flight
//     -> err pulse; only the 0x11 data is returned, with unchanged latency.
//  5. MemWrite 0x30=0xFF, then reset asserted before commit
//     -> all outputs 0; a later read of 0x30 returns the preloaded value, not 0xFF.
//  6. Ten back-to-back reads of 0x00..0x09 (RD_LAT=1)
//     -> rvalid every 2nd cycle with the correct data; err never asserted.

Source files
------------

// File: rtl/mem_responder_if.sv
// Processor-side bus between the multi-cycle core and mem_responder.
// The master drives strobes and address; the slave returns data and status.
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wdone;
  logic              busy;
  logic              err;

  modport master (
    output MemRead,
    output MemWrite,
    output addr,
    output wdata,
    input  rdata,
    input  rvalid,
    input  wdone,
    input  busy,
    input  err
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  addr,
    input  wdata,
    output rdata,
    output rvalid,
    output wdone,
    output busy,
    output err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port instruction/data memory with programmable access latency.
// One request in flight; extra strobes while busy are dropped with err.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wdone_q, wdone_d;
  logic              err_q, err_d;
  logic              ld_wr;
  logic              commit;
  logic              last;

  assign last = (cnt_q == 4'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = 1'b0;
    ld_wr    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_en) begin
          ld_wr = 1'b1;
          err_d = bus.MemRead | bus.MemWrite;
        end else if (bus.MemRead && bus.MemWrite) begin
          err_d = 1'b1;
        end else if (bus.MemRead) begin
          addr_d  = bus.addr;
          cnt_d   = 4'(RD_LAT);
          state_d = RD_WAIT;
        end else if (bus.MemWrite) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = 4'(WR_LAT);
          state_d = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        err_d = bus.MemRead | bus.MemWrite | ld_en;
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          state_d = IDLE;
          if (state_q == RD_WAIT) begin
            rdata_d  = mem[addr_q];
            rvalid_d = 1'b1;
          end else begin
            commit  = 1'b1;
            wdone_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
    end
  end

  // Array has no reset; a write aborted by reset must never land.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (ld_wr)
        mem[ld_addr] <= ld_data;
      else if (commit)
        mem[addr_q] <= wdata_q;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.wdone  = wdone_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus
// hand-written reset-abort and back-to-back sequences.
module tb_mem_responder;

  logic       clock;
  logic       reset;
  logic       ld_en_a, ld_en_b;
  logic [7:0] ld_addr, ld_data;

  int checks = 0;
  int errors = 0;

  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  mem_responder #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(256),
    .RD_LAT(2), .WR_LAT(1)
  ) dut_a (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_a.slave),
    .ld_en   (ld_en_a),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  mem_responder #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(256),
    .RD_LAT(1), .WR_LAT(1)
  ) dut_b (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_b.slave),
    .ld_en   (ld_en_b),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       ld;
    logic [7:0] la;
    logic [7:0] lv;
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] e_rdata;
    logic       e_rv;
    logic       e_wd;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic       ld,
    input logic [7:0] la,
    input logic [7:0] lv,
    input logic       rd,
    input logic       wr,
    input logic [7:0] a,
    input logic [7:0] wd,
    input logic [7:0] e_rdata,
    input logic       e_rv,
    input logic       e_wd,
    input logic       e_busy,
    input logic       e_err
  );
    vec_t v;
    v.ld = ld; v.la = la; v.lv = lv;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.e_rdata = e_rdata; v.e_rv = e_rv;
    v.e_wd = e_wd; v.e_busy = e_busy;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] outs_a();
    return {20'd0, bus_a.rdata, bus_a.rvalid,
            bus_a.wdone, bus_a.busy, bus_a.err};
  endfunction

  function automatic logic [31:0] outs_b();
    return {20'd0, bus_b.rdata, bus_b.rvalid,
            bus_b.wdone, bus_b.busy, bus_b.err};
  endfunction

  function automatic logic [31:0] pk(
    input logic [7:0] rd,
    input logic       rv,
    input logic       wd,
    input logic       bs,
    input logic       er
  );
    return {20'd0, rd, rv, wd, bs, er};
  endfunction

  task automatic idle_a();
    bus_a.MemRead  = 1'b0;
    bus_a.MemWrite = 1'b0;
    ld_en_a        = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ld_en_a = 0; ld_en_b = 0;
    ld_addr = 0; ld_data = 0;
    bus_a.MemRead = 0; bus_a.MemWrite = 0;
    bus_a.addr = 0; bus_a.wdata = 0;
    bus_b.MemRead = 0; bus_b.MemWrite = 0;
    bus_b.addr = 0; bus_b.wdata = 0;

    //             ld la     lv     rd wr a      wd     rdata  rv wd bs er
    tbl[0]  = mk(1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 8'h11, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[2]  = mk(1, 8'h30, 8'h77, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[4]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[5]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 1, 0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 8'h00, 0, 1, 8'h20, 8'h3C, 8'hA5, 0, 0, 1, 0);
    tbl[7]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 0, 1, 0, 0);
    tbl[8]  = mk(0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 8'hA5, 0, 0, 1, 0);
    tbl[9]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 0, 0, 1, 0);
    tbl[10] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3C, 1, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h00, 8'h3C, 0, 0, 0, 1);
    tbl[12] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3C, 0, 0, 0, 0);
    tbl[13] = mk(0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 8'h3C, 0, 0, 1, 0);
    tbl[14] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3C, 0, 0, 1, 0);
    tbl[15] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 1, 0, 0, 0);
    tbl[16] = mk(0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00, 8'hA5, 0, 0, 1, 0);
    tbl[17] = mk(0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 8'hA5, 0, 0, 1, 1);
    tbl[18] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h5A, 1, 0, 0, 0);
    tbl[19] = mk(1, 8'h40, 8'h99, 1, 0, 8'h10, 8'h00, 8'h5A, 0, 0, 0, 1);
    tbl[20] = mk(0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 8'h5A, 0, 0, 1, 0);
    tbl[21] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h5A, 0, 0, 1, 0);
    tbl[22] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h99, 1, 0, 0, 0);
    tbl[23] = mk(0, 8'h00, 8'h00, 0, 1, 8'h50, 8'h12, 8'h99, 0, 0, 1, 0);
    tbl[24] = mk(0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00, 8'h99, 0, 1, 0, 1);
    tbl[25] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h99, 0, 0, 0, 0);
    tbl[26] = mk(0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00, 8'h99, 0, 0, 1, 0);
    tbl[27] = mk(1, 8'h50, 8'hEE, 0, 0, 8'h00, 8'h00, 8'h99, 0, 0, 1, 1);
    tbl[28] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h12, 1, 0, 0, 0);

    step();
    step();
    chk("reset_a", outs_a(), pk(8'h00, 0, 0, 0, 0));
    chk("reset_b", outs_b(), pk(8'h00, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      ld_en_a        = tbl[i].ld;
      ld_addr        = tbl[i].la;
      ld_data        = tbl[i].lv;
      bus_a.MemRead  = tbl[i].rd;
      bus_a.MemWrite = tbl[i].wr;
      bus_a.addr     = tbl[i].a;
      bus_a.wdata    = tbl[i].wd;
      step();
      chk($sformatf("vec%0d", i), outs_a(),
          pk(tbl[i].e_rdata, tbl[i].e_rv,
             tbl[i].e_wd, tbl[i].e_busy,
             tbl[i].e_err));
    end
    idle_a();

    // write 0x30=FF, then reset before it commits
    bus_a.MemWrite = 1'b1;
    bus_a.addr     = 8'h30;
    bus_a.wdata    = 8'hFF;
    step();
    idle_a();
    chk("abort_busy", outs_a(),
        pk(8'h12, 0, 0, 1, 0));
    reset = 1'b1;
    #1;
    chk("abort_rst0", outs_a(), pk(8'h00, 0, 0, 0, 0));
    step();
    chk("abort_rst1", outs_a(), pk(8'h00, 0, 0, 0, 0));
    reset = 1'b0;
    step();
    chk("abort_nowd", outs_a(), pk(8'h00, 0, 0, 0, 0));
    bus_a.MemRead = 1'b1;
    bus_a.addr    = 8'h30;
    step();
    idle_a();
    chk("abort_rd0", outs_a(), pk(8'h00, 0, 0, 1, 0));
    step();
    chk("abort_rd1", outs_a(), pk(8'h00, 0, 0, 1, 0));
    step();
    chk("abort_rd2", outs_a(), pk(8'h77, 1, 0, 0, 0));

    // RD_LAT=1 instance: ten back-to-back reads
    for (int i = 0; i < 10; i++) begin
      ld_en_b = 1'b1;
      ld_addr = 8'(i);
      ld_data = 8'(8'hC0 + i);
      step();
    end
    ld_en_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_b.MemRead = 1'b1;
      bus_b.addr    = 8'(i);
      step();
      bus_b.MemRead = 1'b0;
      chk($sformatf("b2b_acc%0d", i), outs_b(),
          pk((i == 0) ? 8'h00 : 8'(8'hC0 + i - 1),
             0, 0, 1, 0));
      step();
      chk($sformatf("b2b_rv%0d", i), outs_b(),
          pk(8'(8'hC0 + i), 1, 0, 0, 0));
    end
    step();
    chk("b2b_end", outs_b(), pk(8'hC9, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
